// File: rtl/mul_sweep_pkg.sv
// Shared types and width helpers for the multiplier sweep checker.
package mul_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // One extra bit so a full sweep of 2**(2w) pairs cannot wrap.
  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int acc_w(input int w);
    return 4 * w + 1;
  endfunction

endpackage

// File: rtl/if_multiplier.sv
// Operand/product bundle between a multiplier and whatever drives it.
interface if_multiplier #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic [2*WIDTH-1:0] out;
  logic               overflow;

  modport mul_side (input in1, input in2, output out, output overflow);
  modport drv_side (output in1, output in2, input out, input overflow);
endinterface

// File: rtl/mul_err_accum.sv
// Registered compare stage followed by error counters, error sum and max tracker.
module mul_err_accum
  import mul_sweep_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int ACC_W = acc_w(WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        valid,
  input  logic [prod_w(WIDTH)-1:0]    exact,
  input  logic [prod_w(WIDTH)-1:0]    dut_out,
  input  logic                        ovf,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  output logic [cnt_w(WIDTH)-1:0]     err_count,
  output logic [cnt_w(WIDTH)-1:0]     ovf_count,
  output logic [ACC_W-1:0]            sum_abs_err,
  output logic [prod_w(WIDTH)-1:0]    max_err,
  output logic [WIDTH-1:0]            max_a,
  output logic [WIDTH-1:0]            max_b
);

  localparam int PW = prod_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);

  logic             cmp_valid_q, cmp_valid_d;
  logic             cmp_mis_q,   cmp_mis_d;
  logic             cmp_ovf_q,   cmp_ovf_d;
  logic [PW-1:0]    cmp_abs_q,   cmp_abs_d;
  logic [WIDTH-1:0] cmp_a_q,     cmp_a_d;
  logic [WIDTH-1:0] cmp_b_q,     cmp_b_d;

  logic [CW-1:0]    err_cnt_q,   err_cnt_d;
  logic [CW-1:0]    ovf_cnt_q,   ovf_cnt_d;
  logic [ACC_W-1:0] sum_q,       sum_d;
  logic [PW-1:0]    max_q,       max_d;
  logic [WIDTH-1:0] max_a_q,     max_a_d;
  logic [WIDTH-1:0] max_b_q,     max_b_d;

  // Ordering the subtraction keeps the magnitude within PW bits.
  always_comb begin
    cmp_valid_d = valid && !clr;
    cmp_mis_d   = valid && (exact != dut_out);
    cmp_ovf_d   = valid && ovf;
    cmp_abs_d   = (exact >= dut_out) ? (exact - dut_out) : (dut_out - exact);
    cmp_a_d     = a;
    cmp_b_d     = b;
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    sum_d     = sum_q;
    max_d     = max_q;
    max_a_d   = max_a_q;
    max_b_d   = max_b_q;
    if (clr) begin
      err_cnt_d = '0;
      ovf_cnt_d = '0;
      sum_d     = '0;
      max_d     = '0;
      max_a_d   = '0;
      max_b_d   = '0;
    end else if (cmp_valid_q) begin
      err_cnt_d = err_cnt_q + CW'(cmp_mis_q);
      ovf_cnt_d = ovf_cnt_q + CW'(cmp_ovf_q);
      sum_d     = sum_q + ACC_W'(cmp_abs_q);
      // Strict compare: ties keep the earliest pair.
      if (cmp_abs_q > max_q) begin
        max_d   = cmp_abs_q;
        max_a_d = cmp_a_q;
        max_b_d = cmp_b_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_valid_q <= 1'b0;
      cmp_mis_q   <= 1'b0;
      cmp_ovf_q   <= 1'b0;
      cmp_abs_q   <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      err_cnt_q   <= '0;
      ovf_cnt_q   <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      max_a_q     <= '0;
      max_b_q     <= '0;
    end else begin
      cmp_valid_q <= cmp_valid_d;
      cmp_mis_q   <= cmp_mis_d;
      cmp_ovf_q   <= cmp_ovf_d;
      cmp_abs_q   <= cmp_abs_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      err_cnt_q   <= err_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      max_a_q     <= max_a_d;
      max_b_q     <= max_b_d;
    end
  end

  assign err_count   = err_cnt_q;
  assign ovf_count   = ovf_cnt_q;
  assign sum_abs_err = sum_q;
  assign max_err     = max_q;
  assign max_a       = max_a_q;
  assign max_b       = max_b_q;

endmodule

// File: rtl/mul_sweep_checker.sv
// Sweeps every operand pair through a multiplier and accumulates error metrics
// against the exact product.
module mul_sweep_checker
  import mul_sweep_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int DUT_LAT = 0,
  parameter int ACC_W   = acc_w(WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  if_multiplier.drv_side              muif,
  output logic                        busy,
  output logic                        done,
  output logic [cnt_w(WIDTH)-1:0]     err_count,
  output logic [cnt_w(WIDTH)-1:0]     ovf_count,
  output logic [ACC_W-1:0]            sum_abs_err,
  output logic [prod_w(WIDTH)-1:0]    max_err,
  output logic [WIDTH-1:0]            max_a,
  output logic [WIDTH-1:0]            max_b
);

  localparam int PW = prod_w(WIDTH);
  localparam int DW = $clog2(DUT_LAT + 1) + 1;

  typedef struct packed {
    logic             valid;
    logic [PW-1:0]    exact;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pipe_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pair_q,  pair_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          sweep_clr;
  pipe_t         head;
  pipe_t         tail;

  always_comb begin
    state_d   = state_q;
    pair_d    = pair_q;
    drain_d   = drain_q;
    sweep_clr = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          pair_d    = '0;
          sweep_clr = 1'b1;
        end
      end
      RUN: begin
        // The last pair stays on the operands through DRAIN and DONE.
        if (pair_q == '1) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          pair_d = pair_q + PW'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DW'(DUT_LAT)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pair_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      drain_q <= drain_d;
    end
  end

  assign muif.in1 = pair_q[PW-1:WIDTH];
  assign muif.in2 = pair_q[WIDTH-1:0];
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  always_comb begin
    head.valid = (state_q == RUN);
    head.a     = pair_q[PW-1:WIDTH];
    head.b     = pair_q[WIDTH-1:0];
    head.exact = {{WIDTH{1'b0}}, pair_q[PW-1:WIDTH]} * {{WIDTH{1'b0}}, pair_q[WIDTH-1:0]};
  end

  // Delay the reference data by the DUT latency so it lines up with muif.out.
  generate
    if (DUT_LAT == 0) begin : g_no_align
      assign tail = head;
    end else begin : g_align
      pipe_t stage_q [DUT_LAT];
      pipe_t stage_d [DUT_LAT];
      for (genvar gi = 0; gi < DUT_LAT; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          assign stage_d[gi] = head;
        end else begin : g_next
          assign stage_d[gi] = stage_q[gi-1];
        end
        always_ff @(posedge clk) begin
          if (rst) stage_q[gi] <= '0;
          else     stage_q[gi] <= stage_d[gi];
        end
      end
      assign tail = stage_q[DUT_LAT-1];
    end
  endgenerate

  mul_err_accum #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_accum (
    .clk         (clk),
    .rst         (rst),
    .clr         (sweep_clr),
    .valid       (tail.valid),
    .exact       (tail.exact),
    .dut_out     (muif.out),
    .ovf         (muif.overflow),
    .a           (tail.a),
    .b           (tail.b),
    .err_count   (err_count),
    .ovf_count   (ovf_count),
    .sum_abs_err (sum_abs_err),
    .max_err     (max_err),
    .max_a       (max_a),
    .max_b       (max_b)
  );

endmodule

// File: tb/tb_mul_sweep_checker.sv
// Directed bench: combinational multiplier stubs with injected faults, plus a
// two-stage registered multiplier for the latency variant.
module tb_mul_sweep_checker;

  localparam int W = 6;
  localparam int N = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1;
  logic [1:0] mode;

  if_multiplier #(.WIDTH(W)) mif0 ();
  if_multiplier #(.WIDTH(W)) mif1 ();

  logic          busy0, done0, busy1, done1;
  logic [12:0]   err0, ovf0, err1, ovf1;
  logic [24:0]   sum0, sum1;
  logic [11:0]   max0, max1;
  logic [5:0]    maxa0, maxb0, maxa1, maxb1;

  // mode 0 exact, 1 out[0] stuck at 0, 2 +3 at (63,63), 3 overflow when in1==0
  logic [11:0] prod0;
  assign prod0 = {6'd0, mif0.in1} * {6'd0, mif0.in2};
  assign mif0.out = (mode == 2'd1) ? {prod0[11:1], 1'b0} :
                    ((mode == 2'd2) && (mif0.in1 == 6'd63) && (mif0.in2 == 6'd63)) ? prod0 + 12'd3 :
                    prod0;
  assign mif0.overflow = (mode == 2'd3) && (mif0.in1 == 6'd0);

  logic [11:0] p1, p2;
  always @(posedge clk) begin
    p1 <= {6'd0, mif1.in1} * {6'd0, mif1.in2};
    p2 <= p1;
  end
  assign mif1.out      = p2;
  assign mif1.overflow = 1'b0;

  mul_sweep_checker #(.WIDTH(W), .DUT_LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .muif(mif0),
    .busy(busy0), .done(done0), .err_count(err0), .ovf_count(ovf0),
    .sum_abs_err(sum0), .max_err(max0), .max_a(maxa0), .max_b(maxb0)
  );

  mul_sweep_checker #(.WIDTH(W), .DUT_LAT(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .muif(mif1),
    .busy(busy1), .done(done1), .err_count(err1), .ovf_count(ovf1),
    .sum_abs_err(sum1), .max_err(max1), .max_a(maxa1), .max_b(maxb1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("[TB] check %s observed %0d expected %0d", tag, obs, exp);
  endtask

  // cyc = index of the first cycle with done high, start cycle = 0; -1 on timeout.
  task automatic run0(output int cyc);
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 5000; i++) begin
      @(posedge clk); #1;
      if (done0) begin cyc = i + 1; break; end
    end
  endtask

  task automatic run1(input int poke_at, output int cyc);
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 5000; i++) begin
      start1 = (i == poke_at);
      @(posedge clk); #1;
      if (done1) begin cyc = i + 1; break; end
    end
    start1 = 1'b0;
  endtask

  int cyc;

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_err", err0, 0);
    check("rst_sum", sum0, 0);
    check("rst_in1", mif0.in1, 0);
    check("rst_in2", mif0.in2, 0);
    @(negedge clk); rst = 1'b0;

    mode = 2'd0; run0(cyc);
    check("exact_done_cycle", cyc, 4098);
    check("exact_err", err0, 0);
    check("exact_sum", sum0, 0);
    check("exact_max", max0, 0);
    check("exact_max_a", maxa0, 0);
    check("exact_max_b", maxb0, 0);
    check("exact_busy_in_done", busy0, 0);
    check("exact_in1_held", mif0.in1, 63);
    check("exact_in2_held", mif0.in2, 63);

    mode = 2'd1; run0(cyc);
    check("lsb0_done_cycle", cyc, 4098);
    check("lsb0_err", err0, 1024);
    check("lsb0_sum", sum0, 1024);
    check("lsb0_max", max0, 1);
    check("lsb0_max_a", maxa0, 1);
    check("lsb0_max_b", maxb0, 1);

    mode = 2'd2; run0(cyc);
    check("corner_err", err0, 1);
    check("corner_sum", sum0, 3);
    check("corner_max", max0, 3);
    check("corner_max_a", maxa0, 63);
    check("corner_max_b", maxb0, 63);

    mode = 2'd3; run0(cyc);
    check("ovf_count", ovf0, 64);
    check("ovf_err", err0, 0);

    run1(200, cyc);
    check("lat2_done_cycle", cyc, 4100);
    check("lat2_err", err1, 0);
    check("lat2_ovf", ovf1, 0);
    check("lat2_sum", sum1, 0);
    check("lat2_max", max1, 0);
    check("lat2_max_a", maxa1, 0);
    check("lat2_max_b", maxb1, 0);
    check("lat2_busy_in_done", busy1, 0);
    check("lat2_done", done1, 1);

    mode = 2'd1;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    check("abort_busy_before", busy0, 1);
    check("abort_err_nonzero", (err0 != 0), 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_err", err0, 0);
    check("abort_sum", sum0, 0);
    check("abort_max", max0, 0);
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_in1", mif0.in1, 0);
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1;
    check("rst_over_start_busy", busy0, 0);
    @(negedge clk); rst = 1'b0; start0 = 1'b0;
    run0(cyc);
    check("resweep_done_cycle", cyc, 4098);
    check("resweep_err", err0, 1024);
    check("resweep_sum", sum0, 1024);
    check("resweep_max", max0, 1);
    check("resweep_max_a", maxa0, 1);
    check("resweep_max_b", maxb0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
